// File: rtl/lcounter_gen_if.sv
// Handshake/bus bundle between the round-counter generator and its consumer.
// The consumer drives start/step. The generator drives the round value and the status flags.
interface lcounter_gen_if;
    logic        start;
    logic        step;
    logic [15:0] lfsr_out;
    logic [7:0]  round;
    logic        valid;
    logic        last;
    logic        done;
    logic        busy;

    // Consumer side
    modport master (
        output start, step,
        input  lfsr_out, round, valid, last, done, busy
    );

    // Generator side
    modport slave (
        input  start, step,
        output lfsr_out, round, valid, last, done, busy
    );
endinterface

// File: rtl/lcounter_gen.sv
// LFSR-based round-constant generator.
// A start request loads IV and begins round 0. Each step advances the LFSR by one
// position and the round index by one. The step taken at the last round produces a
// one-cycle done pulse, and the generator then returns to idle.
module lcounter_gen #(
    parameter int               WIDTH  = 6,
    parameter logic [WIDTH-1:0] IV     = 6'h05,
    parameter logic [WIDTH-1:0] TAPS   = 6'h30,
    parameter int               ROUNDS = 45
) (
    input  logic          clk,
    input  logic          rst,
    lcounter_gen_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);

    state_t           state_q;
    logic [WIDTH-1:0] lfsr_q;
    logic [7:0]       round_q;
    logic             valid_q;
    logic             last_q;
    logic             done_q;
    logic             busy_q;

    logic [WIDTH-1:0] lfsr_d;
    logic [7:0]       round_d;

    // Candidate next LFSR value and round index for a step in RUN.
    assign lfsr_d  = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    assign round_d = round_q + 8'd1;

    // Sequencer FSM. The status flags are registered alongside the state.
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_RUN;
                        lfsr_q  <= IV;
                        round_q <= 8'd0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        last_q  <= (LAST_ROUND == 8'd0);
                    end
                end
                S_RUN: begin
                    // start is deliberately ignored here; only step matters
                    if (bus.step) begin
                        if (round_q == LAST_ROUND) begin
                            state_q <= S_DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            lfsr_q  <= lfsr_d;
                            round_q <= round_d;
                            last_q  <= (round_d == LAST_ROUND);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // The value outputs are forced to zero whenever the presented round is not valid.
    // The upper bits of lfsr_out are always zero.
    assign bus.lfsr_out = valid_q ? 16'(lfsr_q) : 16'd0;
    assign bus.round    = valid_q ? round_q : 8'd0;
    assign bus.valid    = valid_q;
    assign bus.last     = last_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;

endmodule

// File: doc/lcounter_gen.md
LCOUNTER_GEN -- requirements
Module: lcounter_gen

Interface
REQ-001 Parameter WIDTH, default 6: LFSR register width in bits, legal range 2..16.
REQ-002 Parameter IV, default 6'h05: LFSR value loaded on start (round 0), never zero.
REQ-003 Parameter TAPS, default 6'h30: feedback mask; feedback bit = XOR of lfsr bits where TAPS bit is 1.
REQ-004 Parameter ROUNDS, default 45: number of round values issued per permutation, legal range 1..255.
REQ-005 Port clk  input  1: single clock; all state updates occur on its rising edge.
REQ-006 Port rst  input  1: asynchronous, active-high reset.
REQ-007 Port start  input  1: request a new round sequence.
REQ-008 Port step  input  1: consumer has used the current value; advance to the next round.
REQ-009 Port lfsr_out  output  16: current counter value, zero-extended from WIDTH bits; it feeds the downstream bit-reversal stage.
REQ-010 Port round  output  8: index of the current round, 0..ROUNDS-1.
REQ-011 Port valid  output  1: lfsr_out and round are meaningful.
REQ-012 Port last  output  1: current round is ROUNDS-1.
REQ-013 Port done  output  1: single-cycle pulse after the final round is stepped.
REQ-014 Port busy  output  1: sequence in progress (state RUN).

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 In IDLE, start=1 SHALL load lfsr=IV and round=0, and move to RUN on the same edge.
REQ-017 In RUN, valid=1 and busy=1 SHALL hold; lfsr_out SHALL present the registered lfsr with no combinational path from step.
REQ-018 In RUN, step=1 with round<ROUNDS-1 SHALL update lfsr to {lfsr[WIDTH-2:0], ^(lfsr & TAPS)} and increment round by 1.
REQ-019 In RUN, step=1 with round=ROUNDS-1 SHALL move to DONE and leave lfsr and round unchanged.
REQ-020 In RUN, step=0 SHALL hold all state; there is no timeout.
REQ-021 In RUN, start SHALL be ignored, including when start and step are both 1; step is still honoured.
REQ-022 DONE SHALL last exactly one cycle with done=1, valid=0 and busy=0, then return unconditionally to IDLE; start during DONE SHALL be ignored.
REQ-023 In IDLE, step SHALL be ignored.
REQ-024 When valid=0, lfsr_out, round and last SHALL be driven to 0.
REQ-025 last SHALL equal valid AND (round == ROUNDS-1); with ROUNDS=1, last SHALL be 1 for the whole RUN state.
REQ-026 Latency: start to first valid is 1 cycle; step to next value is 1 cycle; a continuously held step SHALL advance one round per cycle.
REQ-027 Bits 15..WIDTH of lfsr_out SHALL always be 0.

Reset
REQ-028 rst=1 SHALL immediately force state=IDLE, lfsr=0, round=0 and valid=last=done=busy=0, independent of clk.
REQ-029 Reset asserted mid-sequence SHALL abort the sequence with no done pulse.
REQ-030 After reset release, the first start SHALL behave exactly as in REQ-016.

Verification
REQ-031 Reset, then start for 1 cycle, then step held high -> lfsr_out = 0x0005, 0x000A, 0x0014, 0x0029, 0x0013 on consecutive cycles, with round = 0..4.
REQ-032 Full run with defaults, step held high -> 45 valid cycles, last=1 only when round=44, done=1 exactly one cycle after the step at round 44, then IDLE with all outputs 0.
REQ-033 Step applied every third cycle -> each value is held stable between steps, and the sequence matches REQ-031.
REQ-034 start pulsed at round 10 together with step -> round becomes 11 and no reload to IV occurs; step pulsed while in IDLE -> no output change.
REQ-035 rst asserted asynchronously at round 20 (between clock edges) -> outputs go to 0 before the next edge, no done pulse, and the next start yields 0x0005.
REQ-036 Parameters WIDTH=7, IV=7'h7A, TAPS=7'h60, ROUNDS=70 -> the bench model matches lfsr_out for all 70 rounds and bits 15..7 stay 0.
